// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, async instruction-memory read, and a 2-entry {pc, instr} buffer toward decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky misalign flag and halt fetch.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [$clog2(MEM_DEPTH)-1:0] iaddr,
  input  logic [DATA_WIDTH-1:0]        idata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_instr,
  output logic [31:0]                  out_pc,
  output logic                         misalign
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [31:0]           r_pc;
  logic [1:0]            r_count;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_misalign;
  logic [31:0]           r_ent_pc    [2];
  logic [DATA_WIDTH-1:0] r_ent_instr [2];

  logic [31:0] w_pc_nxt;
  logic [1:0]  w_count_nxt;
  logic        w_rd_nxt;
  logic        w_wr_nxt;
  logic        w_mis_nxt;
  logic        w_pop;
  logic        w_push;
  logic        w_halt;
  logic        w_redir_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_redir_mis = |redirect_pc[1:0];
  assign w_halt      = r_misalign;
`else
  // Low redirect bits are discarded when trapping is disabled.
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_redir_mis   = 1'b0;
  assign w_halt        = 1'b0;
`endif

  assign iaddr     = r_pc[AW+1:2];
  assign out_valid = (r_count != 2'd0);
  assign out_instr = out_valid ? r_ent_instr[r_rd] : '0;
  assign out_pc    = out_valid ? r_ent_pc[r_rd] : 32'd0;
  assign misalign  = r_misalign;

  assign w_pop  = out_valid && out_ready;
  assign w_push = !redirect_valid && !w_halt && ((r_count != 2'd2) || w_pop);

  // Next-state: redirect flushes and reloads, otherwise push/pop the buffer.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_mis_nxt   = r_misalign;
    if (redirect_valid) begin
      w_pc_nxt    = {redirect_pc[31:2], 2'b00};
      w_count_nxt = 2'd0;
      w_rd_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_mis_nxt   = w_redir_mis;
    end else begin
      if (w_push) begin
        w_pc_nxt = r_pc + 32'd4;
        w_wr_nxt = ~r_wr;
      end
      if (w_pop) begin
        w_rd_nxt = ~r_rd;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_count    <= 2'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_misalign <= w_mis_nxt;
    end
  end

  // Buffer payload needs no reset; out_* are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_ent_pc[r_wr]    <= r_pc;
      r_ent_instr[r_wr] <= idata;
    end
  end

endmodule
